approx_rca_pipe: RTL and testbench

Parametrised, pipelined approximate ripple-carry adder with valid/ready handshakes and a per-transaction exact/approximate mode select. The lowest LOWER_WIDTH bit positions use the XNOR approximate cell when approximate mode is selected; all other bit positions are exact full adders. The carry chain is split into STAGES registered segments, so throughput is one addition per cycle. The block replaces the fixed 16-bit combinational adders in the approximate arithmetic library wherever a clocked, backpressure-aware adder is needed.

---
 rtl/approx_arith_pkg.sv | 21 ++
 rtl/approx_rca_seg.sv | 37 +++
 rtl/approx_rca_pipe.sv | 188 ++++++++++++++++++
 tb/tb_approx_rca_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_arith_pkg.sv
// Shared helpers for the approximate arithmetic library: full-adder cell
// models and the configuration check used by the adders.
package approx_arith_pkg;

  // Exact full adder, returns {cout, sum}
  function automatic logic [1:0] exact_fa(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  // XNOR approximate cell, returns {cout, sum}; the incoming carry plays no part
  function automatic logic [1:0] xnor_fa(input logic a, input logic b);
    return {a, ~(a ^ b)};
  endfunction

  // Legal configurations: width splits evenly into segments, lower region fits
  function automatic bit params_ok(input int width, input int lower, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0) &&
           (lower >= 0) && (lower <= width);
  endfunction

endpackage

// File: rtl/approx_rca_seg.sv
// Combinational SEG-bit ripple segment. Bit i sits at absolute position
// base+i; positions below LOWER_WIDTH use the XNOR cell when approx is set.
module approx_rca_seg
  import approx_arith_pkg::*;
#(
  parameter int SEG         = 8,
  parameter int LOWER_WIDTH = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           approx,
  input  logic [31:0]    base,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  // Ripple the carry through the segment, picking the cell per bit position
  always_comb begin
    logic       c;
    logic [1:0] cs;
    c   = cin;
    cs  = 2'b00;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      if (approx && ((base + 32'(i)) < 32'(LOWER_WIDTH))) begin
        cs = xnor_fa(a[i], b[i]);
      end else begin
        cs = exact_fa(a[i], b[i], c);
      end
      sum[i] = cs[0];
      c      = cs[1];
    end
    cout = c;
  end

endmodule

// File: rtl/approx_rca_pipe.sv
// Pipelined approximate ripple-carry adder with valid/ready handshakes.
// The carry chain is cut into STAGES registered segments; the whole pipe
// advances together and stalls together when the output is not taken.
// Optional feature: define APPROX_RCA_ERR_EN to add err_o, the absolute
// difference from the exact sum, carried alongside each result.
module approx_rca_pipe
  import approx_arith_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LOWER_WIDTH = 4,
  parameter int STAGES      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             approx_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o
`ifdef APPROX_RCA_ERR_EN
  ,
  output logic [WIDTH:0]   err_o
`endif
);

  localparam int SEG = WIDTH / STAGES;

  if (!params_ok(WIDTH, LOWER_WIDTH, STAGES)) begin : g_bad_cfg
    $error("approx_rca_pipe: WIDTH must be a multiple of STAGES and LOWER_WIDTH <= WIDTH");
  end

  logic advance;

  assign advance    = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;        // first bit handled here
    localparam int UP = WIDTH - LO;     // operand bits not yet consumed

    logic [UP-1:0]       a_in;
    logic [UP-1:0]       b_in;
    logic                carry_in;
    logic                approx_in;
    logic                vld_in;
    logic [SEG-1:0]      seg_sum;
    logic                seg_cout;
    logic [LO+SEG-1:0]   sum_next;
    logic [LO+SEG-1:0]   sum_p;
    logic                carry_p;
    logic                vld_p;

    if (k == 0) begin : g_head
      // Approximate mode injects a carry of 1 into bit 0
      assign a_in      = add1_i;
      assign b_in      = add2_i;
      assign carry_in  = approx_i;
      assign approx_in = approx_i;
      assign vld_in    = in_valid_i;
      assign sum_next  = seg_sum;
    end else begin : g_body
      assign a_in      = g_stage[k-1].g_fwd.a_p;
      assign b_in      = g_stage[k-1].g_fwd.b_p;
      assign carry_in  = g_stage[k-1].carry_p;
      assign approx_in = g_stage[k-1].g_fwd.approx_p;
      assign vld_in    = g_stage[k-1].vld_p;
      assign sum_next  = {seg_sum, g_stage[k-1].sum_p};
    end

    approx_rca_seg #(
      .SEG         (SEG),
      .LOWER_WIDTH (LOWER_WIDTH)
    ) u_seg (
      .a      (a_in[SEG-1:0]),
      .b      (b_in[SEG-1:0]),
      .cin    (carry_in),
      .approx (approx_in),
      .base   (32'(LO)),
      .sum    (seg_sum),
      .cout   (seg_cout)
    );

`ifdef APPROX_RCA_ERR_EN
    // Shadow exact chain so each beat's error is known at the output stage
    logic              ex_cin;
    logic [SEG-1:0]    ex_seg_sum;
    logic              ex_seg_cout;
    logic [LO+SEG-1:0] ex_sum_next;

    if (k == 0) begin : g_ex_head
      assign ex_cin      = 1'b0;
      assign ex_sum_next = ex_seg_sum;
    end else begin : g_ex_body
      assign ex_cin      = g_stage[k-1].g_fwd.ex_carry_p;
      assign ex_sum_next = {ex_seg_sum, g_stage[k-1].g_fwd.ex_sum_p};
    end

    approx_rca_seg #(
      .SEG         (SEG),
      .LOWER_WIDTH (LOWER_WIDTH)
    ) u_ex_seg (
      .a      (a_in[SEG-1:0]),
      .b      (b_in[SEG-1:0]),
      .cin    (ex_cin),
      .approx (1'b0),
      .base   (32'(LO)),
      .sum    (ex_seg_sum),
      .cout   (ex_seg_cout)
    );
`endif

    // ---- stage k register boundary ----
    // Valid bit: cleared by reset so in-flight beats are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_p <= 1'b0;
      end else if (advance) begin
        vld_p <= vld_in;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // Output stage data is cleared on reset so result_o reads zero
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sum_p   <= '0;
          carry_p <= 1'b0;
        end else if (advance) begin
          sum_p   <= sum_next;
          carry_p <= seg_cout;
        end
      end

`ifdef APPROX_RCA_ERR_EN
      logic [WIDTH:0] res_next;
      logic [WIDTH:0] ex_next;
      logic [WIDTH:0] err_p;

      assign res_next = {seg_cout, sum_next};
      assign ex_next  = {ex_seg_cout, ex_sum_next};

      // Absolute error against the exact sum, registered with the result
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          err_p <= '0;
        end else if (advance) begin
          err_p <= (res_next >= ex_next) ? (res_next - ex_next) : (ex_next - res_next);
        end
      end
`else
      // Error tracking not built in this configuration
`endif
    end else begin : g_fwd
      logic [UP-SEG-1:0] a_p;
      logic [UP-SEG-1:0] b_p;
      logic              approx_p;
`ifdef APPROX_RCA_ERR_EN
      logic [LO+SEG-1:0] ex_sum_p;
      logic              ex_carry_p;
`endif

      // Intermediate data needs no reset; it is qualified by vld_p
      always_ff @(posedge clk_i) begin
        if (advance) begin
          sum_p      <= sum_next;
          carry_p    <= seg_cout;
          a_p        <= a_in[UP-1:SEG];
          b_p        <= b_in[UP-1:SEG];
          approx_p   <= approx_in;
`ifdef APPROX_RCA_ERR_EN
          ex_sum_p   <= ex_sum_next;
          ex_carry_p <= ex_seg_cout;
`endif
        end
      end
    end
  end

  assign out_valid_o = g_stage[STAGES-1].vld_p;
  assign result_o    = {g_stage[STAGES-1].carry_p, g_stage[STAGES-1].sum_p};
`ifdef APPROX_RCA_ERR_EN
  assign err_o       = g_stage[STAGES-1].g_tail.err_p;
`endif

endmodule

// File: tb/tb_approx_rca_pipe.sv
// Self-checking bench for approx_rca_pipe (WIDTH=16, LOWER_WIDTH=4, STAGES=2)
// with a queue scoreboard fed at acceptance and drained at output handshakes.
module tb_approx_rca_pipe;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int ST = 2;

  typedef struct {
    logic [W:0] res;
    logic [W:0] err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] add1 = '0;
  logic [W-1:0] add2 = '0;
  logic         approx = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   result;
`ifdef APPROX_RCA_ERR_EN
  logic [W:0]   err;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;
  int   cyc      = 0;
  exp_t q[$];
  int   pop_cyc[$];

  approx_rca_pipe #(
    .WIDTH       (W),
    .LOWER_WIDTH (LW),
    .STAGES      (ST)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .approx_i    (approx),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result)
`ifdef APPROX_RCA_ERR_EN
    ,
    .err_o       (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum, or XNOR low bits with carry a[LW-1] into the upper add
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ap);
    logic [W:0] lo_mask;
    logic [W:0] hi;
    if (!ap) return {1'b0, a} + {1'b0, b};
    if (LW == 0) return {1'b0, a} + {1'b0, b} + 17'd1;
    lo_mask = (17'd1 << LW) - 17'd1;
    hi      = ({1'b0, a} >> LW) + ({1'b0, b} >> LW) + 17'(a[LW-1]);
    return (hi << LW) | ({1'b0, ~(a ^ b)} & lo_mask);
  endfunction

  function automatic logic [W:0] model_err(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ap);
    logic [W:0] m;
    logic [W:0] e;
    m = model_sum(a, b, ap);
    e = {1'b0, a} + {1'b0, b};
    return (m >= e) ? (m - e) : (e - m);
  endfunction

  // Scoreboard: handshakes seen at negedge complete on the following posedge
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("sb_result", 32'(result), 32'(e.res));
`ifdef APPROX_RCA_ERR_EN
          check("sb_err", 32'(err), 32'(e.err));
`endif
          n_pop++;
          pop_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        e.res = model_sum(add1, add2, approx);
        e.err = model_err(add1, add2, approx);
        q.push_back(e);
      end
    end
  end

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
    int waited = 0;
    add1     = a;
    add2     = b;
    approx   = ap;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    #1;
  endtask

  initial begin
    int          base;
    logic [W:0]  hold;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rdy_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Exact 0xFFFF + 1, latency: valid after the edge following acceptance
    send_beat(16'hFFFF, 16'h0001, 1'b0);
    check("lat_accept_edge", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("exact_ffff_1", 32'(result), 32'h10000);
    wait_drain();

    // Approximate 5 + 3 -> 9
    send_beat(16'h0005, 16'h0003, 1'b1);
    @(posedge clk);
    #1;
    check("approx_5_3", 32'(result), 32'h00009);
`ifdef APPROX_RCA_ERR_EN
    check("err_5_3", 32'(err), 32'd1);
`endif
    wait_drain();

    // Approximate 0xFFFF + 1 -> 0x10001
    send_beat(16'hFFFF, 16'h0001, 1'b1);
    @(posedge clk);
    #1;
    check("approx_ffff_1", 32'(result), 32'h10001);
    wait_drain();

    // Back-to-back stream of 8 beats, alternating mode
    base = n_pop;
    for (int i = 0; i < 8; i++) begin
      send_beat(16'($urandom), 16'($urandom), (i % 2) == 1);
    end
    wait_drain();
    check("stream_count", 32'(n_pop - base), 32'd8);
    if (pop_cyc.size() >= base + 8)
      check("stream_spacing", 32'(pop_cyc[base+7] - pop_cyc[base]), 32'd7);

    // Stall with full pipe: hold out_ready low, result must hold
    base      = n_pop;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(16'($urandom), 16'($urandom), (i % 2) == 0);
      end
      begin
        int w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 20);
        check("stall_fill", {31'd0, out_valid}, 32'd1);
        hold = result;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_ready", {31'd0, in_ready}, 32'd0);
          check("stall_hold", 32'(result), 32'(hold));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count", 32'(n_pop - base), 32'd6);

    // Async reset with two beats in flight
    out_ready = 1'b0;
    send_beat(16'h1234, 16'h4321, 1'b0);
    send_beat(16'h00F0, 16'h000F, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Pipe still works after reset
    @(posedge clk);
    #1;
    send_beat(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_exact", 32'(result), 32'h00100);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
